// File: rtl/rtc_gen.sv
// Real-time-clock generator for the CLINT rtc_i input: programmable internal divider or
// synchronised/deglitched external pin, with watchdog fallback and glitch-free source switching.
module rtc_gen #(
    parameter int DIV         = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int TIMEOUT     = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic testmode_i,
    input  logic en_i,
    input  logic ext_sel_i,
    input  logic rtc_ext_i,
    output logic rtc_o,
    output logic tick_o,
    output logic src_ext_o,
    output logic ext_lost_o
);

    localparam int HALF  = DIV / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int FC_W  = $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0]       cnt_r;
    logic                   rtc_int_r;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   ext_f_r;
    logic [FC_W-1:0]        flt_cnt_r;
    logic [WD_W-1:0]        wd_r;
    logic                   rtc_r;
    logic                   tick_r;
    logic                   src_ext_r;
    logic                   ext_lost_r;

    logic                   synced_s;
    logic                   ext_edge_s;
    logic                   want_ext_s;
    logic                   next_rtc_s;
    logic [WD_W-1:0]        wd_nxt_s;

    // Filter edge detect, source request and next watchdog value.
    always_comb begin
        synced_s   = sync_r[SYNC_STAGES-1];
        ext_edge_s = (synced_s != ext_f_r) && (flt_cnt_r == FC_W'(FILTER_LEN - 1));
        want_ext_s = ext_sel_i & ~testmode_i & ~ext_lost_r;
        next_rtc_s = src_ext_r ? ext_f_r : rtc_int_r;
        if (ext_edge_s) begin
            wd_nxt_s = {WD_W{1'b0}};
        end else if (en_i && (wd_r != WD_W'(TIMEOUT))) begin
            wd_nxt_s = wd_r + WD_W'(1'b1);
        end else begin
            wd_nxt_s = wd_r;
        end
    end

    // Internal divider: freezing en_i keeps the phase, it never restarts the period.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r     <= {CNT_W{1'b0}};
            rtc_int_r <= 1'b0;
        end else if (en_i) begin
            if (cnt_r == CNT_W'(HALF - 1)) begin
                cnt_r     <= {CNT_W{1'b0}};
                rtc_int_r <= ~rtc_int_r;
            end else begin
                cnt_r     <= cnt_r + CNT_W'(1'b1);
            end
        end
    end

    // External pin synchroniser and run-length filter; any agreeing sample restarts the run.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_r    <= {SYNC_STAGES{1'b0}};
            ext_f_r   <= 1'b0;
            flt_cnt_r <= {FC_W{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rtc_ext_i};
            if (synced_s == ext_f_r) begin
                flt_cnt_r <= {FC_W{1'b0}};
            end else if (ext_edge_s) begin
                ext_f_r   <= synced_s;
                flt_cnt_r <= {FC_W{1'b0}};
            end else begin
                flt_cnt_r <= flt_cnt_r + FC_W'(1'b1);
            end
        end
    end

    // Watchdog on filtered external edges; lost flag tracks the saturated count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_r       <= {WD_W{1'b0}};
            ext_lost_r <= 1'b0;
        end else begin
            wd_r       <= wd_nxt_s;
            ext_lost_r <= (wd_nxt_s == WD_W'(TIMEOUT));
        end
    end

    // Output stage: the source only changes while rtc_o is low so a high phase is never cut short.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rtc_r     <= 1'b0;
            tick_r    <= 1'b0;
            src_ext_r <= 1'b0;
        end else if (en_i) begin
            if (!rtc_r) begin
                src_ext_r <= want_ext_s;
            end
            rtc_r  <= next_rtc_s;
            tick_r <= next_rtc_s & ~rtc_r;
        end else begin
            tick_r <= 1'b0;
        end
    end

    assign rtc_o      = rtc_r;
    assign tick_o     = tick_r;
    assign src_ext_o  = src_ext_r;
    assign ext_lost_o = ext_lost_r;

endmodule

// File: tb/tb_rtc_gen.sv
// Self-checking bench for rtc_gen: directed scenarios plus random stimulus against a
// behavioural model built from period arithmetic and sample-history windows.
module tb_rtc_gen;

    localparam int DIV  = 8;
    localparam int HALF = DIV / 2;
    localparam int SYNC = 2;
    localparam int FL   = 3;
    localparam int TO   = 64;

    logic clk_i, rst_ni, testmode_i, en_i, ext_sel_i, rtc_ext_i;
    logic rtc_o, tick_o, src_ext_o, ext_lost_o;
    logic u2_rtc, u2_tick, u2_src, u2_lost;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state
    bit m_rtc, m_tick, m_src, m_lost, m_level;
    int m_en_total, m_en_since;
    bit samp_q[$];
    bit flt_q[$];

    rtc_gen #(.DIV(DIV), .SYNC_STAGES(SYNC), .FILTER_LEN(FL), .TIMEOUT(TO)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .testmode_i(testmode_i), .en_i(en_i),
        .ext_sel_i(ext_sel_i), .rtc_ext_i(rtc_ext_i), .rtc_o(rtc_o), .tick_o(tick_o),
        .src_ext_o(src_ext_o), .ext_lost_o(ext_lost_o)
    );

    rtc_gen u_div2 (
        .clk_i(clk_i), .rst_ni(rst_ni), .testmode_i(1'b0), .en_i(1'b1),
        .ext_sel_i(1'b0), .rtc_ext_i(1'b0), .rtc_o(u2_rtc), .tick_o(u2_tick),
        .src_ext_o(u2_src), .ext_lost_o(u2_lost)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rtc = 1'b0; m_tick = 1'b0; m_src = 1'b0; m_lost = 1'b0; m_level = 1'b0;
        m_en_total = 0; m_en_since = 0;
        samp_q = {}; flt_q = {};
        for (int i = 0; i < SYNC; i++) samp_q.push_back(1'b0);
        for (int i = 0; i < FL; i++) flt_q.push_back(1'b0);
    endtask

    // One clock edge: advance the model from the current inputs, then compare all outputs.
    task automatic step();
        bit synced, flip, int_lvl, src_val, want, junk;
        synced = samp_q[0];
        samp_q.push_back(rtc_ext_i);
        junk = samp_q.pop_front();
        flt_q.push_back(synced);
        junk = flt_q.pop_front();
        flip = 1'b1;
        foreach (flt_q[i]) if (flt_q[i] == m_level) flip = 1'b0;
        int_lvl = ((m_en_total / HALF) % 2) == 1;
        src_val = m_src ? m_level : int_lvl;
        want    = ext_sel_i & ~testmode_i & ~m_lost;
        if (en_i) begin
            m_tick = src_val & ~m_rtc;
            if (!m_rtc) m_src = want;
            m_rtc  = src_val;
        end else begin
            m_tick = 1'b0;
        end
        m_en_since = flip ? 0 : m_en_since + int'(en_i);
        m_lost     = (m_en_since >= TO);
        m_en_total = m_en_total + int'(en_i);
        if (flip) m_level = ~m_level;
        @(posedge clk_i);
        #1;
        check("model_rtc_o", rtc_o, m_rtc);
        check("model_tick_o", tick_o, m_tick);
        check("model_src_ext_o", src_ext_o, m_src);
        check("model_ext_lost_o", ext_lost_o, m_lost);
    endtask

    initial begin
        int cnt;
        int hi_len;
        rst_ni = 1'b1; testmode_i = 1'b0; en_i = 1'b1; ext_sel_i = 1'b0; rtc_ext_i = 1'b0;
        #2 rst_ni = 1'b0;
        model_reset();
        @(posedge clk_i); @(posedge clk_i); #1;
        check("reset_rtc_o", rtc_o, 1'b0);
        check("reset_tick_o", tick_o, 1'b0);
        check("reset_src_ext_o", src_ext_o, 1'b0);
        check("reset_ext_lost_o", ext_lost_o, 1'b0);
        rst_ni = 1'b1;

        // DIV=2 legacy toggle and DIV=8 first rise on edge 5
        for (int k = 1; k <= 10; k++) begin
            step();
            check("div2_rtc", u2_rtc, (k >= 2) && (k % 2 == 0));
            check("div2_tick", u2_tick, (k >= 2) && (k % 2 == 0));
            check("div8_first_rise", rtc_o, (k >= 5) && (k <= 8));
            if (k == 10) begin
                check("div2_src", u2_src, 1'b0);
                check("div2_lost", u2_lost, 1'b0);
            end
        end
        for (int k = 11; k <= 14; k++) step();
        check("div8_high_e14", rtc_o, 1'b1);
        en_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("freeze_rtc", rtc_o, 1'b1);
            check("freeze_tick", tick_o, 1'b0);
        end
        en_i = 1'b1;
        for (int k = 0; k < 6; k++) step();

        // External source: switch, 6-edge latency, glitch rejection
        ext_sel_i = 1'b1;
        for (int i = 0; i < 16 && src_ext_o !== 1'b1; i++) step();
        check("ext_switch", src_ext_o, 1'b1);
        step(); step();
        rtc_ext_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 5) check("ext_lat_e5", rtc_o, 1'b0);
        end
        check("ext_lat_e6", rtc_o, 1'b1);
        check("ext_lat_tick", tick_o, 1'b1);
        for (int k = 0; k < 10; k++) step();
        rtc_ext_i = 1'b0; step(); step();
        rtc_ext_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check("glitch_rtc", rtc_o, 1'b1);
            check("glitch_tick", tick_o, 1'b0);
        end
        for (int p = 0; p < 3; p++) begin
            rtc_ext_i = 1'b0; for (int k = 0; k < 20; k++) step();
            rtc_ext_i = 1'b1; for (int k = 0; k < 20; k++) step();
        end

        // Watchdog: ext stuck low, lost after TIMEOUT, fallback, then recovery
        rtc_ext_i = 1'b0;
        for (int i = 0; i < 10 && rtc_o !== 1'b0; i++) step();
        check("stuck_rtc_low", rtc_o, 1'b0);
        cnt = 0;
        while (ext_lost_o !== 1'b1 && cnt < 100) begin step(); cnt++; end
        check_int("lost_latency", cnt, TO - 1);
        step();
        check("lost_fallback", src_ext_o, 1'b0);
        rtc_ext_i = 1'b1;
        for (int i = 0; i < 40 && src_ext_o !== 1'b1; i++) step();
        check("recover_lost", ext_lost_o, 1'b0);
        check("recover_src", src_ext_o, 1'b1);

        // Source change requested while rtc_o is high waits for the low phase
        ext_sel_i = 1'b0; rtc_ext_i = 1'b0;
        for (int i = 0; i < 20 && src_ext_o !== 1'b0; i++) step();
        check("t4_to_int", src_ext_o, 1'b0);
        for (int i = 0; i < 8 && rtc_o !== 1'b0; i++) step();
        for (int i = 0; i < 8 && rtc_o !== 1'b1; i++) step();
        check("t4_rtc_high", rtc_o, 1'b1);
        ext_sel_i = 1'b1;
        hi_len = 0;
        for (int i = 0; i < 8 && rtc_o === 1'b1; i++) begin
            hi_len++;
            check("t4_src_hold", src_ext_o, 1'b0);
            step();
        end
        check_int("t4_high_len", hi_len, HALF);
        check("t4_src_at_fall", src_ext_o, 1'b0);
        step();
        check("t4_src_after", src_ext_o, 1'b1);
        check("t4_rtc_low", rtc_o, 1'b0);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            en_i = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 63) == 0) ext_sel_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) testmode_i = ~testmode_i;
            if ($urandom_range(0, 9) == 0) rtc_ext_i = ~rtc_ext_i;
            step();
        end

        // Testmode forces internal source; async reset mid-period
        testmode_i = 1'b1; ext_sel_i = 1'b1; en_i = 1'b1; rtc_ext_i = 1'b0;
        for (int k = 0; k < 40; k++) step();
        check("testmode_src", src_ext_o, 1'b0);
        for (int i = 0; i < 16 && rtc_o !== 1'b1; i++) step();
        check("pre_reset_high", rtc_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        check("async_rtc_o", rtc_o, 1'b0);
        check("async_tick_o", tick_o, 1'b0);
        check("async_src_ext_o", src_ext_o, 1'b0);
        check("async_ext_lost_o", ext_lost_o, 1'b0);
        model_reset();
        @(posedge clk_i); @(posedge clk_i); #1;
        testmode_i = 1'b0; ext_sel_i = 1'b0;
        rst_ni = 1'b1;
        for (int k = 0; k < 12; k++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
